// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the key-driven memory slot sequencer.
package mem_seq_pkg;

    localparam int SLOTS            = 4;
    localparam int DATA_W           = 3;
    localparam int SEL_W            = $clog2(SLOTS);
    localparam int DEBOUNCE_DEFAULT = 500000;
    localparam int SCAN_DEFAULT     = 50000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SCAN  = 2'd2
    } state_t;

    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SLOTS-1:0]  keys_t;

    function automatic keys_t onehot(sel_t s);
        return keys_t'(1) << s;
    endfunction

    function automatic logic single_low(keys_t k);
        return $countones(~k) == 1;
    endfunction

    // Key n addresses slot SLOTS-1-n.
    function automatic sel_t key_slot(keys_t k);
        sel_t s;
        s = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!k[i]) s = sel_t'(SLOTS - 1 - i);
        end
        return s;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer for one key.
module key_debounce
    import mem_seq_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic synced,
    output logic level
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          meta;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b1;
            synced <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
        end else begin
            meta   <= key;
            synced <= meta;
            if (synced != level) begin
                if (cnt == CW'(CYCLES - 1)) begin
                    level <= synced;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_sequencer.sv
// Selects and writes slots of a 4x3 memory from debounced push buttons,
// with an optional auto-scan mode that steps through the slots.
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int SCAN_CYCLES     = SCAN_DEFAULT
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [3:0]  KEY,
    input  logic [2:0]  SW_DATA,
    input  logic        SW_WE,
    input  logic        SW_SCAN,
    output logic [1:0]  MEM_SEL,
    output logic [2:0]  MEM_DIN,
    output logic        MEM_WE,
    output logic [3:0]  LEDR
);

    localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    keys_t         synced;
    keys_t         deb;
    keys_t         prev;
    logic [1:0]    settle;
    logic          armed;
    logic [CW-1:0] cnt;
    state_t        state;
    logic          key_evt;
    sel_t          slot;
    sel_t          sel_inc;

    for (genvar g = 0; g < SLOTS; g++) begin : g_key
        key_debounce #(
            .CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (CLOCK_50),
            .rst_n  (RESET_N),
            .key    (KEY[g]),
            .synced (synced[g]),
            .level  (deb[g])
        );
    end

    // Keys held through reset must be seen released before any event.
    assign key_evt = armed && (prev == '1) && single_low(deb);
    assign slot    = key_slot(deb);
    assign sel_inc = MEM_SEL + sel_t'(1);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            MEM_SEL <= '0;
            MEM_DIN <= '0;
            MEM_WE  <= 1'b0;
            LEDR    <= 4'b0001;
            cnt     <= '0;
            prev    <= '1;
            settle  <= '0;
            armed   <= 1'b0;
        end else begin
            prev   <= deb;
            MEM_WE <= 1'b0;
            if (settle != 2'd3) begin
                settle <= settle + 2'd1;
            end else if (&synced && &deb) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (key_evt) begin
                        MEM_SEL <= slot;
                        LEDR    <= onehot(slot);
                        if (SW_WE) begin
                            MEM_DIN <= SW_DATA;
                            MEM_WE  <= 1'b1;
                            state   <= WRITE;
                        end
                    end else if (SW_SCAN) begin
                        cnt   <= '0;
                        state <= SCAN;
                    end
                end
                WRITE: begin
                    cnt   <= '0;
                    state <= SW_SCAN ? SCAN : IDLE;
                end
                SCAN: begin
                    if (key_evt) begin
                        MEM_SEL <= slot;
                        LEDR    <= onehot(slot);
                        cnt     <= '0;
                        if (SW_WE) begin
                            MEM_DIN <= SW_DATA;
                            MEM_WE  <= 1'b1;
                            state   <= WRITE;
                        end
                    end else if (!SW_SCAN) begin
                        state <= IDLE;
                    end else if (cnt == CW'(SCAN_CYCLES - 1)) begin
                        MEM_SEL <= sel_inc;
                        LEDR    <= onehot(sel_inc);
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning clocks a key level must be stable before it is accepted.
REQ-002 SHALL have parameter SCAN_CYCLES, default 50000000, meaning clocks per slot dwell in scan mode.
REQ-003 SHALL have port CLOCK_50  input  1  the single clock; every flop SHALL be clocked on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port KEY  input  4  push buttons, active-low, asynchronous to CLOCK_50.
REQ-006 SHALL have port SW_DATA  input  3  data to be written to the memory.
REQ-007 SHALL have port SW_WE  input  1  write-arm level; a key event while high writes the selected slot.
REQ-008 SHALL have port SW_SCAN  input  1  scan-mode level.
REQ-009 SHALL have port MEM_SEL  output  2  slot address to the 4x3 memory.
REQ-010 SHALL have port MEM_DIN  output  3  write data to the memory.
REQ-011 SHALL have port MEM_WE  output  1  single-cycle write strobe to the memory.
REQ-012 SHALL have port LEDR  output  4  one-hot copy of MEM_SEL (bit n high when MEM_SEL==n).

Function
REQ-013 Each KEY bit SHALL pass a 2-flop synchronizer, then a debouncer whose output changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive clocks; any bounce restarts the count.
REQ-014 A key event SHALL fire for one cycle when the debounced vector goes from 4'b1111 to exactly one bit low; key n maps to slot 3-n (KEY[3] -> slot 0, KEY[0] -> slot 3).
REQ-015 Multi-key patterns, and transitions between two pressed patterns, SHALL produce no event; a new event requires return to all-released.
REQ-016 FSM states SHALL be IDLE, WRITE, SCAN.
REQ-017 IDLE: key event with SW_WE=0 SHALL load MEM_SEL=slot next cycle, stay IDLE; with SW_WE=1 SHALL load MEM_SEL=slot, MEM_DIN=SW_DATA sampled in the event cycle, go to WRITE.
REQ-018 IDLE with SW_SCAN=1 and no event SHALL go to SCAN with the dwell counter cleared.
REQ-019 WRITE SHALL last exactly one cycle with MEM_WE=1; MEM_WE SHALL be 0 in all other states; exit to SCAN if SW_SCAN=1, else IDLE.
REQ-020 SCAN: dwell counter SHALL count 0..SCAN_CYCLES-1; at terminal count MEM_SEL SHALL increment modulo 4 (3 wraps to 0) and the counter clear.
REQ-021 SCAN: key event SHALL take priority over the dwell advance in the same cycle, load MEM_SEL=slot, clear the counter, and go to WRITE if SW_WE=1.
REQ-022 SCAN with SW_SCAN=0 and no event SHALL return to IDLE holding MEM_SEL.
REQ-023 MEM_SEL and MEM_DIN SHALL hold their values in every cycle not explicitly loaded; MEM_SEL and MEM_DIN SHALL be stable throughout the MEM_WE cycle.
REQ-024 All outputs SHALL be registered; key-event-to-output latency SHALL be one clock.

Reset
REQ-025 RESET_N low SHALL immediately force state IDLE, MEM_SEL=0, MEM_DIN=0, MEM_WE=0, LEDR=4'b0001, debounced keys=4'b1111, synchronizers=1, all counters=0.
REQ-026 Reset asserted during WRITE SHALL drop MEM_WE the same instant; no write SHALL be issued after release until a new event.
REQ-027 Keys held low across reset release SHALL not generate an event until released and pressed again.

Structure
REQ-028 State enum, slot count (4), data width (3) and parameter defaults SHALL live in shared package mem_seq_pkg.
REQ-029 Synchronizer plus debouncer SHALL be sub-module key_debounce, instantiated once per KEY bit.

Verification (DEBOUNCE_CYCLES=4, SCAN_CYCLES=8)
REQ-030 KEY=4'b1101 held 10 clocks, SW_WE=0 -> MEM_SEL=2, LEDR=4'b0100, MEM_WE never high.
REQ-031 SW_WE=1, SW_DATA=5, KEY=4'b0111 -> exactly one MEM_WE pulse with MEM_SEL=0, MEM_DIN=5; holding key produces no second pulse.
REQ-032 KEY bit toggling every 2 clocks for 20 clocks -> no event, MEM_SEL unchanged.
REQ-033 KEY=4'b0011 -> no event; then KEY=4'b1111, KEY=4'b1110 -> MEM_SEL=3.
REQ-034 SW_SCAN=1 from MEM_SEL=3 -> MEM_SEL 0,1,2 every 8 clocks; event coinciding with terminal count -> MEM_SEL=event slot, counter restarts.
REQ-035 RESET_N pulsed low during WRITE -> MEM_WE=0 at once, all outputs at reset values, no write after release.
